// File: rtl/speed_pkg.sv
// Shared types and helpers for the meteor speed/difficulty controller.
package speed_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        MAXED = 2'd3
    } state_e;

    // Exactly one select high picks its base; any other combination falls back to the default.
    function automatic int unsigned mode_base(
        input logic        slow_i,
        input logic        normal_i,
        input logic        fast_i,
        input int unsigned b_slow,
        input int unsigned b_normal,
        input int unsigned b_fast,
        input int unsigned b_default
    );
        case ({slow_i, normal_i, fast_i})
            3'b100:  return b_slow;
            3'b010:  return b_normal;
            3'b001:  return b_fast;
            default: return b_default;
        endcase
    endfunction

endpackage

// File: rtl/speed_sat_add.sv
// Per-channel speed: base + level*STEP + OFFSET, clamped to MAX_SPEED (combinational).
module speed_sat_add #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LVL_W     = 5,
    parameter int unsigned STEP      = 1,
    parameter int unsigned OFFSET    = 0,
    parameter int unsigned MAX_SPEED = 200
) (
    input  logic [WIDTH-1:0] base_i,
    input  logic [LVL_W-1:0] level_i,
    output logic [WIDTH-1:0] sum_o
);

    // Wide enough that the unclamped sum can never wrap.
    localparam int unsigned SW = WIDTH + LVL_W + 8;

    logic [SW-1:0] sum_full;

    assign sum_full = SW'(base_i) + SW'(level_i) * SW'(STEP) + SW'(OFFSET);
    assign sum_o    = (sum_full > SW'(MAX_SPEED)) ? WIDTH'(MAX_SPEED) : sum_full[WIDTH-1:0];

endmodule

// File: rtl/speed_ramp_ctrl.sv
// Meteor game difficulty controller: mode-selected base speed ramped one level every
// FRAMES_PER_LVL frames, fanned out to N_CH saturating lane speeds.
module speed_ramp_ctrl
    import speed_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned N_CH           = 4,
    parameter int unsigned LVL_W          = 5,
    parameter int unsigned FRAMES_PER_LVL = 120,
    parameter int unsigned STEP           = 1,
    parameter int unsigned CH_SPREAD      = 1,
    parameter int unsigned MAX_SPEED      = 200,
    parameter int unsigned BASE_SLOW      = 1,
    parameter int unsigned BASE_NORMAL    = 3,
    parameter int unsigned BASE_FAST      = 7,
    parameter int unsigned BASE_DEFAULT   = 20
) (
    input  logic                    i_clk,
    input  logic                    reset,
    input  logic                    slow,
    input  logic                    normal,
    input  logic                    fast,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    restart,
    input  logic                    frame,
    output logic [N_CH*WIDTH-1:0]   speed,
    output logic [LVL_W-1:0]        level,
    output logic                    level_up,
    output logic                    at_max,
    output logic [1:0]              state
);

    localparam int unsigned           FC_W    = (FRAMES_PER_LVL > 1) ? $clog2(FRAMES_PER_LVL) : 1;
    localparam logic [FC_W-1:0]       FC_LAST = FC_W'(FRAMES_PER_LVL - 1);
    localparam logic [LVL_W-1:0]      LVL_TOP = '1;
    localparam logic [WIDTH-1:0]      MAX_W   = WIDTH'(MAX_SPEED);

    state_e                  state_q, state_d;
    logic [WIDTH-1:0]        base_q, base_d;
    logic [WIDTH-1:0]        base_live, base_sel;
    logic [LVL_W-1:0]        level_q, level_d, level_sel;
    logic [FC_W-1:0]         fcnt_q, fcnt_d;
    logic                    level_up_q, level_up_d;
    logic                    at_max_q;
    logic [N_CH*WIDTH-1:0]   speed_q, speed_d;

    assign base_live = WIDTH'(mode_base(slow, normal, fast,
                                        BASE_SLOW, BASE_NORMAL, BASE_FAST, BASE_DEFAULT));

    // IDLE previews the live mode at level 0; every other state uses the latched base.
    always_comb begin
        base_sel  = base_q;
        level_sel = level_q;
        if (state_q == IDLE) begin
            base_sel  = base_live;
            level_sel = '0;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        speed_sat_add #(
            .WIDTH     (WIDTH),
            .LVL_W     (LVL_W),
            .STEP      (STEP),
            .OFFSET    (k * CH_SPREAD),
            .MAX_SPEED (MAX_SPEED)
        ) u_sat (
            .base_i  (base_sel),
            .level_i (level_sel),
            .sum_o   (speed_d[k*WIDTH +: WIDTH])
        );
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        level_d    = level_q;
        fcnt_d     = fcnt_q;
        level_up_d = 1'b0;
        if (restart) begin
            state_d = IDLE;
            level_d = '0;
            fcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        base_d  = base_live;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (speed_q[WIDTH-1:0] == MAX_W) begin
                        state_d = MAXED;
                    end else if (frame) begin
                        if (fcnt_q == FC_LAST) begin
                            fcnt_d = '0;
                            if (level_q != LVL_TOP) begin
                                level_d    = level_q + LVL_W'(1);
                                level_up_d = 1'b1;
                            end
                        end else begin
                            fcnt_d = fcnt_q + FC_W'(1);
                        end
                    end
                end
                PAUSE: begin
                    if (!pause) state_d = RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            level_q    <= '0;
            fcnt_q     <= '0;
            level_up_q <= 1'b0;
            at_max_q   <= 1'b0;
            speed_q    <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            level_q    <= level_d;
            fcnt_q     <= fcnt_d;
            level_up_q <= level_up_d;
            at_max_q   <= (state_d == MAXED);
            speed_q    <= speed_d;
        end
    end

    assign speed    = speed_q;
    assign level    = level_q;
    assign level_up = level_up_q;
    assign at_max   = at_max_q;
    assign state    = state_q;

endmodule

// File: doc/speed_ramp_ctrl.md
# speed_ramp_ctrl

Parametrised, multi-channel difficulty/speed controller for the meteor game. It derives a base speed from the player's slow/normal/fast selection and ramps it up one level every `FRAMES_PER_LVL` video frames. It drives `N_CH` per-lane meteor speeds, each offset by a lane spread and saturated at `MAX_SPEED`. It sits between the button/switch inputs and the meteor movement logic, and provides run, pause, maxed-out and restart control.

## Interface
- `WIDTH`, 8: bits per channel speed; requires `MAX_SPEED < 2**WIDTH`.
- `N_CH`, 4: number of meteor lanes/channels.
- `LVL_W`, 5: level counter width.
- `FRAMES_PER_LVL`, 120: frame pulses per level step; must be ≥1.
- `STEP`, 1: speed added per level.
- `CH_SPREAD`, 1: extra speed per channel index.
- `MAX_SPEED`, 200: saturation ceiling.
- `BASE_SLOW`, `BASE_NORMAL`, `BASE_FAST`, `BASE_DEFAULT`, 1 / 3 / 7 / 20: mode base speeds, each ≤ `MAX_SPEED`.
- `i_clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `slow`, `normal`, `fast` in 1 each: mode selects.
- `start` in 1: leave IDLE.
- `pause` in 1: level-sensitive freeze.
- `restart` in 1: return to IDLE.
- `frame` in 1: one-cycle pulse per video frame.
- `speed` out `N_CH*WIDTH`: channel *k* occupies `[k*WIDTH +: WIDTH]`.
- `level` out `LVL_W`: current level.
- `level_up` out 1: one-cycle pulse on each level increment.
- `at_max` out 1: high while in MAXED.
- `state` out 2: IDLE=0, RUN=1, PAUSE=2, MAXED=3.

## Operation
- **Mode decode:**
  - Exactly one of `slow`/`normal`/`fast` high: that base.
  - Any other combination: `BASE_DEFAULT`.
  - The decode is live in IDLE and latched into `base_q` on the IDLE→RUN transition. After that, the mode inputs are ignored until the block returns to IDLE.
- **Channel speed:** `speed[k] = min(base + level*STEP + k*CH_SPREAD, MAX_SPEED)`.
  - Computed at width `WIDTH+LVL_W+8` so it never wraps.
  - Registered.
- **Frame counter `fcnt`:** range 0..`FRAMES_PER_LVL-1`.
- **IDLE:**
  - Speeds track the live decode with `level=0`.
  - `start` → RUN; latch the base.
  - `frame` is ignored.
- **RUN:**
  - `pause` → PAUSE. Pause wins over a same-cycle `frame`, which is dropped.
  - Otherwise, on `frame`: `fcnt++`.
  - At `fcnt==FRAMES_PER_LVL-1`: `fcnt←0`, `level++`, pulse `level_up`.
  - At `level == 2**LVL_W-1`: `level` holds, no `level_up` pulse, `fcnt` still wraps.
- **RUN → MAXED:** the cycle after the registered `speed[0]` (the smallest channel) equals `MAX_SPEED`.
- **PAUSE:** `fcnt`, `level` and speeds are held; `frame` is ignored; `pause` low → RUN.
- **MAXED:** terminal. All speeds equal `MAX_SPEED`, `at_max=1`, and `frame`/`pause`/`start` are ignored.
- **Priority:** `reset` > `restart` > `pause` > `start`/`frame`.
- **`restart`** (any state): `state←IDLE`, `level←0`, `fcnt←0`, `level_up←0`, `at_max←0`. Speeds follow the IDLE rule from the next cycle.
- **Reset values:** every `speed` channel 0, `level` 0, `level_up` 0, `at_max` 0, `state` IDLE, `fcnt` 0, `base_q` 0.

## Timing
- `frame` sampled at edge N completing a level:
  - `level` and `level_up` are updated at N.
  - `speed` reflects the new level at N+1.
- In IDLE, a mode input change appears on `speed` 1 cycle later.
- `start` at edge N: `state=RUN` after N.
- MAXED entry is 1 cycle after the saturated `speed[0]` appears, which is 2 cycles after the causing level increment.
- `at_max` rises together with `state=MAXED`.
- `restart` or `reset` asserted mid-operation takes effect at the same edge. No partial increment is visible.
- `level_up` is never high for 2 consecutive cycles unless `FRAMES_PER_LVL=1` and `frame` is held high.

## Structure
- Package `speed_pkg`:
  - state encoding constants (IDLE/RUN/PAUSE/MAXED);
  - mode-decode function returning a base speed.
- Sub-module `speed_sat_add`:
  - one instance per channel via generate;
  - combinational `base + level*STEP + k*CH_SPREAD`, clamped to `MAX_SPEED`;
  - the output register lives in the parent.

## Test plan
- **Reset:** hold `reset` 2 cycles with random inputs → all speeds 0, `level=0`, `state=0`, `at_max=0`. Assert `reset` and `restart` together → same values.
- **Mode decode** (`N_CH=4`, defaults):
  - `normal` only in IDLE → speeds {3,4,5,6} one cycle later.
  - `slow`+`fast` → {20,21,22,23}.
  - `fast` latched, then switch to `slow` in RUN → speeds unchanged.
- **Ramp** (`FRAMES_PER_LVL=2`, `fast`): `start`, then 4 `frame` pulses → exactly 2 `level_up` pulses, `level=2`, speeds {9,10,11,12} one cycle after the second increment.
- **Pause:**
  - In RUN with `fcnt=1`, hold `pause` for 3 `frame` pulses, including one coincident with the `pause` rising edge → `level` and `fcnt` unchanged.
  - Release `pause`, give 1 `frame` → level increments.
- **Saturation** (`MAX_SPEED=10`, `STEP=2`, `FRAMES_PER_LVL=1`, `fast`):
  - level 1 → {9,10,10,10};
  - level 2 → all 10, then `at_max=1`, `state=3`;
  - further frames → no change, no `level_up`.
- **Restart:** `restart` coincident with a level-completing `frame` in RUN → `level=0`, IDLE, no `level_up`. Speeds show the IDLE base next cycle.
